// File: rtl/sipo_desern_if.sv
// Serial-in / parallel-out deserialiser bus: serial side driven by the source,
// parallel word and status returned to the consumer.
interface sipo_desern_if #(
    parameter int N = 8
);
    localparam int CW = $clog2(N + 1);

    logic          START;
    logic          SIN;
    logic          SVALID;
    logic [N-1:0]  POUT;
    logic          LOAD;
    logic          BUSY;
    logic [CW-1:0] COUNT;
    logic          ERR;

    modport master (
        output START, SIN, SVALID,
        input  POUT, LOAD, BUSY, COUNT, ERR
    );

    modport slave (
        input  START, SIN, SVALID,
        output POUT, LOAD, BUSY, COUNT, ERR
    );
endinterface

// File: rtl/sipo_desern.sv
// N-bit deserialiser: gathers N qualified serial bits and presents the word on
// POUT with a one-cycle LOAD strobe that feeds a downstream PIPO enable.
module sipo_desern #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         CLK,
    input  logic         n_res,
    sipo_desern_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sr, sr_nxt;
    logic [N-1:0]  pout_q, pout_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_q, load_nxt;
    logic          err_q, err_nxt;
    logic          last, done;

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] v, input logic b);
        if (LSB_FIRST) shift_in = {b, v[N-1:1]};
        else           shift_in = {v[N-2:0], b};
    endfunction

    assign last = (cnt == CW'(N - 1));
    assign done = (state == SHIFT) && bus.SVALID && last;

    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            state  <= IDLE;
            sr     <= '0;
            pout_q <= '0;
            cnt    <= '0;
            load_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            pout_q <= pout_nxt;
            cnt    <= cnt_nxt;
            load_q <= load_nxt;
            err_q  <= err_nxt;
        end
    end

    // A START on the completing bit keeps us in SHIFT for the next frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = SHIFT;
            SHIFT:   if (done && !bus.START) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion has priority over START, so the completing bit is never an abort.
    always_comb begin
        sr_nxt   = sr;
        cnt_nxt  = cnt;
        pout_nxt = pout_q;
        load_nxt = 1'b0;
        err_nxt  = err_q;
        if (done) begin
            pout_nxt = shift_in(sr, bus.SIN);
            load_nxt = 1'b1;
            sr_nxt   = '0;
            cnt_nxt  = '0;
        end else if (bus.START) begin
            err_nxt = err_q | (state == SHIFT);
            sr_nxt  = bus.SVALID ? shift_in({N{1'b0}}, bus.SIN) : {N{1'b0}};
            cnt_nxt = bus.SVALID ? CW'(1) : CW'(0);
        end else if ((state == SHIFT) && bus.SVALID) begin
            sr_nxt  = shift_in(sr, bus.SIN);
            cnt_nxt = cnt + CW'(1);
        end
    end

    assign bus.POUT  = pout_q;
    assign bus.LOAD  = load_q;
    assign bus.BUSY  = (state == SHIFT);
    assign bus.COUNT = cnt;
    assign bus.ERR   = err_q;
endmodule

// File: tb/tb_sipo_desern.sv
// Directed bench for sipo_desern: LSB-first and MSB-first instances plus a
// behavioural PIPO register fed by LOAD/POUT.
module tb_sipo_desern;
    logic CLK = 1'b0;
    logic n_res;
    always #5 CLK = ~CLK;

    sipo_desern_if #(.N(8)) ifa ();
    sipo_desern_if #(.N(8)) ifb ();

    sipo_desern #(.N(8), .LSB_FIRST(1'b1)) dut_a (.CLK(CLK), .n_res(n_res), .bus(ifa));
    sipo_desern #(.N(8), .LSB_FIRST(1'b0)) dut_b (.CLK(CLK), .n_res(n_res), .bus(ifb));

    int total = 0;
    int bad   = 0;
    int loads_a = 0;
    int loads_b = 0;
    logic [7:0] q_pipo;

    // Downstream PIPO register: EN = LOAD, D = POUT.
    always_ff @(posedge CLK) if (ifa.LOAD) q_pipo <= ifa.POUT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        if (ifa.LOAD === 1'b1) loads_a++;
        if (ifb.LOAD === 1'b1) loads_b++;
    endtask

    task automatic bit_a(input logic st, input logic sv, input logic s);
        ifa.START = st; ifa.SVALID = sv; ifa.SIN = s;
        cyc();
        ifa.START = 1'b0; ifa.SVALID = 1'b0; ifa.SIN = 1'b0;
    endtask

    task automatic bit_b(input logic st, input logic sv, input logic s);
        ifb.START = st; ifb.SVALID = sv; ifb.SIN = s;
        cyc();
        ifb.START = 1'b0; ifb.SVALID = 1'b0; ifb.SIN = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        n_res = 1'b0;
        ifa.START = 1'b0; ifa.SVALID = 1'b0; ifa.SIN = 1'b0;
        ifb.START = 1'b0; ifb.SVALID = 1'b0; ifb.SIN = 1'b0;
        #2;
        chk("rst_pout",  ifa.POUT,  8'h00);
        chk("rst_load",  ifa.LOAD,  1'b0);
        chk("rst_busy",  ifa.BUSY,  1'b0);
        chk("rst_count", ifa.COUNT, 4'd0);
        chk("rst_err",   ifa.ERR,   1'b0);
        #10 n_res = 1'b1;

        // SVALID alone in IDLE is ignored
        bit_a(1'b0, 1'b1, 1'b1);
        chk("idle_ign_count", ifa.COUNT, 4'd0);
        chk("idle_ign_busy",  ifa.BUSY,  1'b0);

        // Frame 1: A6 LSB-first, consecutive bits
        pat = 8'hA6;
        for (int i = 0; i < 8; i++) begin
            bit_a(i == 0, 1'b1, pat[i]);
            if (i < 7) begin
                chk("f1_count", ifa.COUNT, i + 1);
                chk("f1_pout_hold", ifa.POUT, 8'h00);
                chk("f1_load_lo", ifa.LOAD, 1'b0);
            end
        end
        chk("f1_load", ifa.LOAD, 1'b1);
        chk("f1_pout", ifa.POUT, 8'hA6);
        chk("f1_busy", ifa.BUSY, 1'b0);
        chk("f1_count0", ifa.COUNT, 4'd0);
        cyc();
        chk("f1_load_off", ifa.LOAD, 1'b0);
        chk("f1_pipo_q", q_pipo, 8'hA6);
        chk("f1_loads", loads_a, 1);

        // Frame 2: MSB-first instance, arrival order 1,0,1,0,0,1,1,0
        for (int j = 0; j < 8; j++) bit_b(j == 0, 1'b1, pat[7 - j]);
        chk("f2_load", ifb.LOAD, 1'b1);
        chk("f2_pout", ifb.POUT, 8'hA6);
        cyc();
        chk("f2_load_off", ifb.LOAD, 1'b0);
        chk("f2_loads", loads_b, 1);

        // Frame 3: 3C with 1..3 idle cycles between bits
        pat = 8'h3C;
        bit_a(1'b1, 1'b0, 1'b0);
        chk("f3_start_count", ifa.COUNT, 4'd0);
        chk("f3_start_busy", ifa.BUSY, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat ((i % 3) + 1) cyc();
            if (i > 0) chk("f3_gap_count", ifa.COUNT, i);
            bit_a(1'b0, 1'b1, pat[i]);
            if (i < 7) begin
                chk("f3_count", ifa.COUNT, i + 1);
                chk("f3_pout_hold", ifa.POUT, 8'hA6);
            end
        end
        chk("f3_pout", ifa.POUT, 8'h3C);
        chk("f3_load", ifa.LOAD, 1'b1);
        chk("f3_count0", ifa.COUNT, 4'd0);
        chk("f3_loads", loads_a, 2);

        // Frame 4: abort after 4 bits, restart with 5A
        bit_a(1'b1, 1'b0, 1'b0);
        bit_a(1'b0, 1'b1, 1'b1);
        bit_a(1'b0, 1'b1, 1'b0);
        bit_a(1'b0, 1'b1, 1'b1);
        bit_a(1'b0, 1'b1, 1'b1);
        chk("f4_pre_count", ifa.COUNT, 4'd4);
        chk("f4_pre_err", ifa.ERR, 1'b0);
        pat = 8'h5A;
        bit_a(1'b1, 1'b1, pat[0]);
        chk("f4_abort_err", ifa.ERR, 1'b1);
        chk("f4_abort_count", ifa.COUNT, 4'd1);
        chk("f4_abort_busy", ifa.BUSY, 1'b1);
        chk("f4_abort_load", ifa.LOAD, 1'b0);
        chk("f4_abort_pout", ifa.POUT, 8'h3C);
        for (int i = 1; i < 8; i++) bit_a(1'b0, 1'b1, pat[i]);
        chk("f4_pout", ifa.POUT, 8'h5A);
        chk("f4_load", ifa.LOAD, 1'b1);
        cyc();
        chk("f4_err_sticky", ifa.ERR, 1'b1);
        chk("f4_loads", loads_a, 3);

        // Reset to clear ERR
        @(negedge CLK) n_res = 1'b0;
        #1;
        chk("r2_err", ifa.ERR, 1'b0);
        chk("r2_pout", ifa.POUT, 8'h00);
        @(negedge CLK) n_res = 1'b1;

        // Frame 5: START on the 8th bit of A6, then FF
        pat = 8'hA6;
        for (int i = 0; i < 8; i++) bit_a((i == 0) || (i == 7), 1'b1, pat[i]);
        chk("f5a_load", ifa.LOAD, 1'b1);
        chk("f5a_pout", ifa.POUT, 8'hA6);
        chk("f5a_busy", ifa.BUSY, 1'b1);
        chk("f5a_count", ifa.COUNT, 4'd0);
        chk("f5a_err", ifa.ERR, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_a(1'b0, 1'b1, 1'b1);
            if (i == 0) chk("f5b_load_single", ifa.LOAD, 1'b0);
            if (i < 7) chk("f5b_busy", ifa.BUSY, 1'b1);
        end
        chk("f5b_pout", ifa.POUT, 8'hFF);
        chk("f5b_load", ifa.LOAD, 1'b1);
        chk("f5b_busy_end", ifa.BUSY, 1'b0);
        chk("f5b_err", ifa.ERR, 1'b0);
        chk("f5_loads", loads_a, 5);

        // Frame 6: reset after 5 bits, then 81
        for (int i = 0; i < 5; i++) bit_a(i == 0, 1'b1, 1'b1);
        chk("f6_pre_count", ifa.COUNT, 4'd5);
        @(negedge CLK) n_res = 1'b0;
        #1;
        chk("f6_rst_pout", ifa.POUT, 8'h00);
        chk("f6_rst_count", ifa.COUNT, 4'd0);
        chk("f6_rst_busy", ifa.BUSY, 1'b0);
        chk("f6_rst_err", ifa.ERR, 1'b0);
        chk("f6_rst_load", ifa.LOAD, 1'b0);
        @(negedge CLK) n_res = 1'b1;
        chk("f6_no_load", loads_a, 5);
        pat = 8'h81;
        for (int i = 0; i < 8; i++) bit_a(i == 0, 1'b1, pat[i]);
        chk("f6_pout", ifa.POUT, 8'h81);
        chk("f6_load", ifa.LOAD, 1'b1);
        cyc();
        chk("f6_load_off", ifa.LOAD, 1'b0);
        chk("f6_loads", loads_a, 6);
        chk("f6_pipo_q", q_pipo, 8'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sipo_desern.md
Name: sipo_deserN

Overview:
N-bit serial-in/parallel-out deserialiser that sits directly upstream of the N-bit PIPO register (d_ffN).
- Collects N qualified serial bits into a frame.
- Presents the assembled word on POUT with a one-cycle LOAD strobe.
- LOAD drives the PIPO EN pin and POUT drives its D bus, so the PIPO captures the word on the edge after LOAD rises.

Parameters:
N, 8, data width in bits (N >= 2).
LSB_FIRST, 1, 1 = first received bit lands in POUT[0]; 0 = first received bit lands in POUT[N-1].

Ports:
CLK  input  1  rising-edge clock.
n_res  input  1  asynchronous active-low reset.
START  input  1  frame start; qualifies the same-cycle SVALID bit as bit 0.
SIN  input  1  serial data bit.
SVALID  input  1  SIN is valid this cycle.
POUT  output  N  assembled parallel word; held stable between frames.
LOAD  output  1  one-cycle strobe: POUT holds a newly completed word (to PIPO EN).
BUSY  output  1  frame in progress (state SHIFT).
COUNT  output  $clog2(N+1)  bits captured in the current frame.
ERR  output  1  sticky: a frame was aborted by START; cleared only by reset.

Behaviour:
- Reset (n_res=0, asynchronous, overrides all):
  - POUT=0, LOAD=0, BUSY=0, COUNT=0, ERR=0.
  - Internal shift register cleared; state IDLE.
  - Release takes effect on the first rising CLK edge after n_res=1.
- States: IDLE and SHIFT. All outputs are registered.
- IDLE:
  - SVALID without START is ignored.
  - START=1 -> SHIFT, shift register cleared, COUNT=0.
  - If SVALID=1 in the same cycle as START, SIN is captured as bit 0 and COUNT=1.
- SHIFT, each SVALID=1 captures SIN:
  - LSB_FIRST=1: sr <= {SIN, sr[N-1:1]}.
  - LSB_FIRST=0: sr <= {sr[N-2:0], SIN}.
  - COUNT increments. SVALID=0 holds sr and COUNT (gaps allowed, no timeout).
- Completion (edge capturing bit N):
  - POUT <= final sr value, LOAD=1 for exactly the following cycle.
  - COUNT <= 0; state -> IDLE; BUSY=0.
  - Latency: LOAD high one cycle after the Nth qualified bit.
- POUT changes only on completion or reset; no partial word ever appears on POUT.
- START during SHIFT with COUNT<N-1 after this edge (i.e. not the completing bit):
  - Abort: partial word discarded, ERR <= 1, new frame started.
  - COUNT=0, or 1 if SVALID is also high (that SIN is the new bit 0).
  - No LOAD pulse.
- START coinciding with the completing bit (SVALID=1, COUNT=N-1):
  - Completion wins: SIN is bit N-1 of the current frame; LOAD pulses; POUT updates.
  - New frame starts with COUNT=0, state stays SHIFT, BUSY stays 1, no ERR.
- Back-to-back frames: a new frame may start in the LOAD cycle; LOAD never exceeds one cycle per completed frame.
- Reset mid-frame: partial data lost, no LOAD, outputs go to reset values immediately.
- COUNT range is 0..N-1 when observed; it never shows N.

Test Plan:
- N=8, LSB_FIRST=1, reset then START with bits 0,1,1,0,0,1,0,1 on consecutive SVALID cycles:
  - POUT=8'hA6, LOAD high exactly 1 cycle, one cycle after the 8th bit.
  - Downstream d_ffN with EN=LOAD holds Q=8'hA6 on the following edge.
- LSB_FIRST=0, bits 1,0,1,0,0,1,1,0 -> POUT=8'hA6, LOAD single pulse.
- Random SVALID gaps (1-3 idle cycles between bits), pattern 8'h3C LSB-first:
  - POUT stays at its previous value (8'hA6) until the 8th bit.
  - Then POUT=8'h3C; COUNT steps 0..7 and back to 0.
- Abort: START, 4 bits, START again, then 8 bits of 8'h5A:
  - ERR=1 sticky; only one LOAD; POUT=8'h5A.
- START asserted on the 8th bit of 8'hA6, followed by 8 bits of 8'hFF:
  - Two LOAD pulses, with POUT=8'hA6 then 8'hFF; ERR=0; BUSY continuous across the boundary.
- n_res pulsed low after 5 bits, then full frame 8'h81:
  - Immediately POUT=0, COUNT=0, BUSY=0, ERR=0, no LOAD.
  - Then POUT=8'h81 with a single LOAD.
